// File: rtl/regfile_xfer_seq_if.sv
// Register-file / data-memory port bundle owned by the block-transfer sequencer.
// The master side is the sequencer; the slave side is the datapath and memory.
interface regfile_xfer_seq_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
);
  logic             start;
  logic             L;
  logic             U;
  logic             W;
  logic [3:0]       Rn;
  logic [NREGS-1:0] reglist;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] RD;
  logic             busy;
  logic             done;
  logic [3:0]       A2;
  logic [3:0]       A3;
  logic             WE3;
  logic [WIDTH-1:0] WD3;
  logic [WIDTH-1:0] MemAddr;
  logic             MemWrite;

  modport master (
    input  start, L, U, W, Rn, reglist, base, RD,
    output busy, done, A2, A3, WE3, WD3, MemAddr, MemWrite
  );

  modport slave (
    output start, L, U, W, Rn, reglist, base, RD,
    input  busy, done, A2, A3, WE3, WD3, MemAddr, MemWrite
  );
endinterface

// File: rtl/regfile_xfer_seq.sv
// LDM/STM block-transfer sequencer: moves one register per cycle between the
// register file and data memory, lowest register at lowest address, optional base writeback.
module regfile_xfer_seq #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input  logic               clk,
  input  logic               reset,
  regfile_xfer_seq_if.master bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_XFER  = 2'd1;
  localparam logic [1:0] S_WBACK = 2'd2;

  logic [1:0]       state;
  logic             done_q;
  logic             l_q;
  logic             wb_q;
  logic [3:0]       rn_q;
  logic [NREGS-1:0] remaining;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] final_addr;
  logic [WIDTH-1:0] offset;
  logic [3:0]       idx;
  logic             last;
  logic             accept;

  function automatic logic [4:0] popcount(input logic [NREGS-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [NREGS-1:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = NREGS - 1; i >= 0; i--) if (v[i]) r = 4'(i);
    return r;
  endfunction

  assign accept = (state == S_IDLE) && bus.start;
  assign offset = WIDTH'(popcount(bus.reglist)) << 2;
  assign idx    = lowest_set(remaining);
  assign last   = (remaining & (remaining - NREGS'(1))) == '0;

  // Control: state and done pulse are the only reset-sensitive flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.reglist == '0) done_q <= 1'b1;
            else                   state  <= S_XFER;
          end
        end
        S_XFER: begin
          if (last) begin
            if (wb_q) begin
              state <= S_WBACK;
            end else begin
              state  <= S_IDLE;
              done_q <= 1'b1;
            end
          end
        end
        S_WBACK: begin
          state  <= S_IDLE;
          done_q <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Command capture and per-transfer advance; outputs are gated by state, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      l_q        <= bus.L;
      rn_q       <= bus.Rn;
      wb_q       <= bus.W && !(bus.L && bus.reglist[bus.Rn]);
      remaining  <= bus.reglist;
      addr       <= bus.U ? bus.base : bus.base - offset;
      final_addr <= bus.U ? bus.base + offset : bus.base - offset;
    end else if (state == S_XFER) begin
      remaining <= remaining & (remaining - NREGS'(1));
      addr      <= addr + WIDTH'(4);
    end
  end

  always_comb begin
    bus.busy     = (state != S_IDLE);
    bus.done     = done_q;
    bus.A2       = '0;
    bus.A3       = '0;
    bus.WE3      = 1'b0;
    bus.WD3      = '0;
    bus.MemAddr  = '0;
    bus.MemWrite = 1'b0;
    if (state == S_XFER) begin
      bus.MemAddr = addr;
      if (l_q) begin
        bus.A3  = idx;
        bus.WD3 = bus.RD;
        bus.WE3 = 1'b1;
      end else begin
        bus.A2       = idx;
        bus.MemWrite = 1'b1;
      end
    end else if (state == S_WBACK) begin
      bus.A3  = rn_q;
      bus.WD3 = final_addr;
      bus.WE3 = 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_xfer_seq.sv
// Bench for regfile_xfer_seq: directed table, reset corner cases and random commands
// against a per-cycle transfer-list model.
module tb_regfile_xfer_seq;
  localparam int WIDTH = 32;

  typedef struct packed {
    logic        l;
    logic        u;
    logic        w;
    logic [3:0]  rn;
    logic [15:0] reglist;
    logic [31:0] base;
    logic [31:0] rd_key;
  } cmd_t;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [3:0]  a2;
    logic [3:0]  a3;
    logic        we3;
    logic [31:0] wd3;
    logic [31:0] mem_addr;
    logic        mem_write;
  } obs_t;

  typedef struct {
    string name;
    cmd_t  cmd;
    int    exp_done;
    int    exp_we;
    int    exp_mw;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic [31:0] rd_key;
  int vectors = 0;
  int miss = 0;
  obs_t exp_q[$];
  vec_t tbl[6];

  always #5 clk = ~clk;

  regfile_xfer_seq_if #(.WIDTH(WIDTH), .NREGS(16)) bus ();
  regfile_xfer_seq #(.WIDTH(WIDTH), .NREGS(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Data memory: read data is a keyed function of the address.
  assign bus.RD = bus.MemAddr ^ rd_key;

  function automatic obs_t observe();
    obs_t o;
    o.busy      = bus.busy;
    o.done      = bus.done;
    o.a2        = bus.A2;
    o.a3        = bus.A3;
    o.we3       = bus.WE3;
    o.wd3       = bus.WD3;
    o.mem_addr  = bus.MemAddr;
    o.mem_write = bus.MemWrite;
    return o;
  endfunction

  task automatic check_obs(input string nm, input obs_t got, input obs_t want);
    vectors++;
    if (got !== want) begin
      miss++;
      $display("FAIL %s: got %h required %h", nm, got, want);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    vectors++;
    if (got != want) begin
      miss++;
      $display("FAIL %s: got %0d required %0d", nm, got, want);
    end
  endtask

  // Expected cycle-by-cycle picture: one entry per transfer, optional writeback, then done.
  task automatic build_expect(input cmd_t c);
    int n;
    logic [31:0] a;
    logic [31:0] fin;
    obs_t o;
    exp_q.delete();
    n = 0;
    for (int i = 0; i < 16; i++) if (c.reglist[i]) n++;
    a   = c.u ? c.base : c.base - 32'(4 * n);
    fin = c.u ? c.base + 32'(4 * n) : c.base - 32'(4 * n);
    for (int i = 0; i < 16; i++) begin
      if (c.reglist[i]) begin
        o = '0;
        o.busy = 1'b1;
        o.mem_addr = a;
        if (c.l) begin
          o.a3 = 4'(i);
          o.we3 = 1'b1;
          o.wd3 = a ^ c.rd_key;
        end else begin
          o.a2 = 4'(i);
          o.mem_write = 1'b1;
        end
        exp_q.push_back(o);
        a = a + 32'd4;
      end
    end
    if (n != 0 && c.w && !(c.l && c.reglist[c.rn])) begin
      o = '0;
      o.busy = 1'b1;
      o.a3 = c.rn;
      o.we3 = 1'b1;
      o.wd3 = fin;
      exp_q.push_back(o);
    end
    o = '0;
    o.done = 1'b1;
    exp_q.push_back(o);
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_cmd(input cmd_t c, input string nm, input bit chk,
                         input int e_done, input int e_we, input int e_mw);
    int done_at;
    int nwe;
    int nmw;
    obs_t o;
    build_expect(c);
    rd_key      = c.rd_key;
    bus.L       = c.l;
    bus.U       = c.u;
    bus.W       = c.w;
    bus.Rn      = c.rn;
    bus.reglist = c.reglist;
    bus.base    = c.base;
    bus.start   = 1'b1;
    done_at = -1;
    nwe = 0;
    nmw = 0;
    for (int cyc = 0; cyc < 40 && done_at < 0; cyc++) begin
      @(negedge clk);
      o = observe();
      if (cyc == 0) begin
        // Command inputs must not be re-sampled once accepted.
        bus.start   = 1'b0;
        bus.L       = ~c.l;
        bus.U       = ~c.u;
        bus.W       = ~c.w;
        bus.Rn      = 4'($urandom);
        bus.reglist = 16'($urandom);
        bus.base    = $urandom;
      end
      if (cyc < exp_q.size())
        check_obs($sformatf("%s cyc%0d", nm, cyc), o, exp_q[cyc]);
      nwe += int'(o.we3);
      nmw += int'(o.mem_write);
      if (o.done) done_at = cyc;
    end
    if (done_at < 0) begin
      miss++;
      vectors++;
      $display("FAIL %s timeout: done never seen in 40 cycles, required cycle %0d", nm, exp_q.size() - 1);
    end
    if (chk) begin
      check_int({nm, " done_cycle"}, done_at, e_done);
      check_int({nm, " we3_count"}, nwe, e_we);
      check_int({nm, " memwrite_count"}, nmw, e_mw);
    end
  endtask

  initial begin
    cmd_t c;
    obs_t want;

    //              l     u     w     rn     reglist   base          rd_key
    tbl[0] = '{"stm_ia",   '{1'b0, 1'b1, 1'b0, 4'd0,  16'h000B, 32'h0000_0100, 32'h0}, 3, 0, 3};
    tbl[1] = '{"ldm_db_wb", '{1'b1, 1'b0, 1'b1, 4'd13, 16'h00F0, 32'h0000_0200, 32'hA5}, 5, 5, 0};
    tbl[2] = '{"empty",    '{1'b0, 1'b1, 1'b1, 4'd3,  16'h0000, 32'h0000_0300, 32'h0}, 0, 0, 0};
    tbl[3] = '{"ldm_rn_in", '{1'b1, 1'b1, 1'b1, 4'd2,  16'h0006, 32'h0000_0040, 32'h1234}, 2, 2, 0};
    tbl[4] = '{"wrap",     '{1'b0, 1'b1, 1'b1, 4'd9,  16'h0003, 32'hFFFF_FFFC, 32'h0}, 3, 1, 2};
    tbl[5] = '{"stm_db_wb", '{1'b0, 1'b0, 1'b1, 4'd1,  16'h8002, 32'h0000_0008, 32'h0}, 3, 1, 2};

    reset       = 1'b1;
    rd_key      = '0;
    bus.start   = 1'b0;
    bus.L       = 1'b0;
    bus.U       = 1'b0;
    bus.W       = 1'b0;
    bus.Rn      = '0;
    bus.reglist = '0;
    bus.base    = '0;
    repeat (3) @(negedge clk);
    check_obs("reset_state", observe(), '0);
    reset = 1'b0;

    // Directed table; entries 1 and 2 are issued back-to-back in the done cycle.
    for (int i = 0; i < 6; i++) begin
      if (i != 2) @(negedge clk);
      run_cmd(tbl[i].cmd, tbl[i].name, 1'b1, tbl[i].exp_done, tbl[i].exp_we, tbl[i].exp_mw);
    end

    // Reset in the middle of a full-list STM, with a start pulse while busy.
    @(negedge clk);
    rd_key      = '0;
    bus.L       = 1'b0;
    bus.U       = 1'b1;
    bus.W       = 1'b1;
    bus.Rn      = 4'd0;
    bus.reglist = 16'hFFFF;
    bus.base    = 32'h0000_1000;
    bus.start   = 1'b1;
    @(negedge clk);
    want = '0;
    want.busy = 1'b1;
    want.mem_addr = 32'h0000_1000;
    want.mem_write = 1'b1;
    check_obs("rst_xfer0", observe(), want);
    bus.L       = 1'b1;
    bus.reglist = 16'h0001;
    @(negedge clk);
    want.a2 = 4'd1;
    want.mem_addr = 32'h0000_1004;
    check_obs("start_while_busy_ignored", observe(), want);
    bus.start = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    check_obs("reset_mid_xfer", observe(), '0);
    bus.start   = 1'b1;
    bus.reglist = 16'h000F;
    @(negedge clk);
    check_obs("reset_over_start", observe(), '0);
    reset     = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check_obs("idle_after_reset", observe(), '0);
    c = '{1'b1, 1'b1, 1'b1, 4'd5, 16'h0101, 32'h0000_0800, 32'h0F0F_0F0F};
    run_cmd(c, "post_reset_ldm", 1'b1, 3, 3, 0);

    // Random commands, some back-to-back, some with wrapping bases.
    for (int t = 0; t < 80; t++) begin
      c.l       = 1'($urandom);
      c.u       = 1'($urandom);
      c.w       = 1'($urandom);
      c.rn      = 4'($urandom);
      c.reglist = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      c.base    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFC0 + 32'($urandom_range(0, 127)))
                                               : $urandom;
      c.base[1:0] = 2'b00;
      c.rd_key  = $urandom;
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      run_cmd(c, $sformatf("rand%0d", t), 1'b0, 0, 0, 0);
    end

    @(negedge clk);
    check_obs("final_idle", observe(), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule

// File: doc/regfile_xfer_seq.md
# regfile_xfer_seq

Multi-register transfer sequencer that acts as the initiator for the register file's three-port interface (A2 read, A3/WE3/WD3 write). On a single start command it runs an ARM-style block transfer (LDM/STM), one register per cycle, between the register file and data memory, with optional base writeback. It sits in the ARM controller/datapath next to the register file and takes over the register file ports and memory strobes while busy.

## Interface
- WIDTH, 32, data/address width
- NREGS, 16, register count; the list is NREGS bits and indices are 4 bits
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- start  in  1  command strobe; accepted only in IDLE
- L  in  1  1 = load multiple (memory to registers), 0 = store multiple
- U  in  1  1 = increment-after, 0 = decrement-before
- W  in  1  base writeback enable
- Rn  in  4  base register index
- reglist  in  16  register list; bit i selects Ri
- base  in  WIDTH  current value of Rn, supplied by the datapath and valid with start
- RD  in  WIDTH  memory read data, combinational from MemAddr
- busy  out  1  sequencer owns the register file and memory ports
- done  out  1  one-cycle completion pulse
- A2  out  4  register file read address; STM data comes from RD2 into memory
- A3  out  4  register file write address
- WE3  out  1  register file write enable
- WD3  out  WIDTH  register file write data
- MemAddr  out  WIDTH  memory address
- MemWrite  out  1  memory write strobe

## Operation
- States: IDLE, XFER, WBACK.
- **IDLE, start=1:**
  - Latch L, U, W, Rn, reglist as `remaining`, and n = popcount(reglist).
  - Set addr = base (U=1) or base − 4·n (U=0).
  - Set final = base + 4·n (U=1) or base − 4·n (U=0).
  - Go to XFER. If reglist = 0, go directly to IDLE with done instead.
- **XFER, each cycle:**
  - idx = lowest set bit of `remaining`, so the lowest register always maps to the lowest address.
  - MemAddr = addr.
  - STM: A2 = idx, MemWrite = 1.
  - LDM: A3 = idx, WD3 = RD, WE3 = 1.
  - At the edge: clear bit idx and set addr += 4.
  - When the last bit clears, go to WBACK if W = 1 and not (L = 1 and bit Rn was set in the list). Otherwise go to IDLE with done.
- **WBACK, one cycle:** A3 = Rn, WD3 = final, WE3 = 1, then IDLE with done.
- **Conflicts:**
  - LDM with W and Rn in the list: the loaded value wins and writeback is skipped.
  - STM with Rn in the list stores the pre-writeback base.
- **Arithmetic:** all arithmetic is modulo 2^WIDTH. The address wraps silently, with no error.
- **Idle outputs:** in IDLE, A2 = A3 = 0, WD3 = 0, MemAddr = 0, WE3 = MemWrite = 0.
- **start while busy:** ignored, not queued.
- **Inputs after acceptance:** the block never re-samples base, L, U, W, Rn or reglist after accepting start.

## Timing
- **Reset:** state = IDLE and every output is 0 (busy, done, WE3, MemWrite, A2, A3, WD3, MemAddr).
- **Reset mid-operation:** aborts immediately. No WE3 or MemWrite in the cycle after reset is sampled high. Reset has priority over start.
- **Start acceptance:** start is sampled at edge E0.
- **busy:** high from E0 until the edge that enters IDLE, covering XFER and WBACK cycles only.
- **Transfer cycles:** transfer k (k = 0..n−1) is driven during cycle k after E0 and committed at its closing edge. The register file write and memory write occur on that edge.
- **WBACK:** occupies cycle n when taken.
- **done latency:** done is a registered pulse, high for exactly one cycle in IDLE.
  - n cycles after E0 + 1 without writeback.
  - n + 1 cycles after E0 + 1 with writeback.
  - One cycle after E0 for an empty list.
- **start in the done cycle:** accepted, so back-to-back commands are supported.
- **Output type:** WE3, MemWrite, A2, A3, WD3 and MemAddr are decoded from registered state and are glitch-free per cycle. WD3 in LDM follows RD combinationally.

## Test plan
1. **STM increment-after:** reglist=0x000B, base=0x100, U=1, W=0.
   - Cycles 0..2: MemAddr 0x100/0x104/0x108 with A2=0/1/3 and MemWrite=1.
   - done in cycle 3; WE3 never asserted.
2. **LDM decrement-before with writeback:** reglist=0x00F0, Rn=13, base=0x200, U=0, W=1, RD=addr^0xA5.
   - Cycles 0..3: MemAddr 0x1F0..0x1FC; A3=4..7 with WD3=RD and WE3=1.
   - Cycle 4: A3=13, WD3=0x1F0, WE3=1.
   - done in cycle 5.
3. **Empty list:** reglist=0, W=1 → no WE3 or MemWrite, busy stays 0, done one cycle after start.
4. **LDM with Rn in list:** reglist=0x0006, Rn=2, W=1, U=1, base=0x40.
   - Two loads to r1/r2 at 0x40/0x44.
   - No WBACK cycle; done in cycle 2.
5. **Reset mid-transfer:** reset asserted after the first STM transfer of reglist=0xFFFF.
   - Next cycle all outputs are 0 and busy=0.
   - A start pulsed during busy (before the reset) produced nothing.
   - A new start after reset runs normally.
6. **Address wrap:** base=0xFFFFFFFC, U=1, reglist=0x0003, STM, W=1 → MemAddr 0xFFFFFFFC then 0x00000000, then WBACK WD3=0x00000004.
